icache_assoc: RTL and testbench
===============================

// Module: icache_assoc
// PURPOSE
//  Parametrised set-associative instruction cache between the datapath's icache port
//  (imemREN/imemaddr in; ihit/imemload out) and the memory controller's instruction
//  port (iREN/iaddr out; iwait/iload in).
//  Generalises the fixed icache to configurable sets, ways and words per block.
//  Adds multi-word block fills, round-robin replacement and a whole-cache invalidate (iflush).
// PARAMETERS
//  SETS       8   number of sets, power of 2, >=2
//  WAYS       2   associativity: 1, 2 or 4
//  BLK_WORDS  2   32-bit words per block, power of 2, >=1
// PORTS
//  CLK       in   1   clock, rising edge
//  RST       in   1   synchronous, active-high reset
//  imemREN   in   1   datapath fetch request
//  imemaddr  in   32  fetch byte address (word aligned)
//  iflush    in   1   invalidate all lines (1-cycle pulse)
//  ihit      out  1   imemload valid this cycle
//  imemload  out  32  fetched instruction
//  iREN      out  1   memory read request
//  iaddr     out  32  memory word address
//  iwait     in   1   memory busy; iload valid when iREN && !iwait
//  iload     in   32  memory read data
// BEHAVIOUR
//  - One clock (CLK). Reset is synchronous and active-high (RST). It clears all valid bits,
//    round-robin pointers and the fill counter, and puts the FSM in IDLE.
//  - Out of reset: iREN=0, iaddr=0, ihit=0, imemload=0.
//  - Address split: [1:0] byte offset (ignored); then blkoff=log2(BLK_WORDS) bits;
//    then index=log2(SETS) bits; the remaining upper bits are the tag.
//  - Storage per set/way: valid bit, tag, BLK_WORDS data words. One rr_ptr per set
//    (log2(WAYS) bits).
//  - Hit, combinational: ihit = imemREN && state==IDLE && some valid way has a matching tag.
//    imemload is the addressed word of that way; 0 when ihit=0. Hit latency is 0 cycles.
//  - FSM IDLE:
//    - IDLE -> FILL when imemREN && !hit && !iflush. Latch tag and index; cnt=0.
//    - Victim way: lowest-numbered invalid way; otherwise the way at rr_ptr[index].
//  - FSM FILL:
//    - iREN=1, iaddr={tag,index,cnt,2'b00}. Words are fetched in order 0..BLK_WORDS-1.
//    - Each cycle with !iwait: write iload into the victim way at word cnt; cnt++.
//    - On the last word: set the victim's valid bit and tag; rr_ptr[index]++ (mod WAYS,
//      on every fill); go to IDLE.
//    - The line hits on the cycle after it returns to IDLE (miss penalty =
//      BLK_WORDS*(wait+1)+1 cycles).
//  - iflush in IDLE: all valid bits clear at the next edge; ihit is forced 0 in the same cycle.
//  - iflush in FILL: valid bits clear and the fill aborts: state=IDLE, iREN=0 the next cycle.
//    The partially filled line stays invalid. The memory controller tolerates an
//    abandoned request.
//  - imemREN falling during FILL: the fill still completes. imemaddr changing mid-fill has no
//    effect on the fill in progress.
//  - iflush has priority over both the fill-complete and the miss transitions.
//  - Reset has priority over everything. Reset mid-fill drops iREN the next cycle and
//    leaves no line valid.
//  - WAYS=1: rr_ptr is unused; the victim is always way 0.
// TESTING (SETS=8, WAYS=2, BLK_WORDS=2: index=addr[5:3], tag=addr[31:6])
//  1 Cold miss: reset, then imemREN=1, imemaddr=0x40, iwait high 2 cycles per word.
//    -> iaddr 0x40 then 0x44, iREN=1 throughout; ihit=1 one cycle after the 2nd word,
//    imemload=word@0x40. Then imemaddr=0x44 -> immediate ihit with word@0x44.
//  2 Conflict and replacement: fill 0x40, 0x80, 0xC0 (all index 0).
//    -> 0xC0 evicts way0 (0x40). Re-access of 0x80 hits; 0x40 misses and evicts way1 (0x80).
//  3 Flush in IDLE: with 0x40 resident, pulse iflush.
//    -> ihit=0 that cycle; next access to 0x40 misses with iREN=1, iaddr=0x40.
//  4 Flush mid-fill: miss on 0x100 with iwait=1, pulse iflush during the word-0 request.
//    -> iREN=0 next cycle; a later access to 0x100 refills from iaddr 0x100.
//  5 No request: imemREN=0 with imemaddr=0x200 (miss).
//    -> ihit=0, imemload=0, iREN stays 0 for 10 cycles.
//  6 Reset mid-fill: assert RST during the word-1 request of a 0x40 fill.
//    -> iREN=0, state IDLE; 0x40 misses afterwards.

Source files
------------

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with multi-word block fill, round-robin replacement
// and a single-cycle whole-cache invalidate.
module icache_assoc #(
  parameter int SETS      = 8,
  parameter int WAYS      = 2,
  parameter int BLK_WORDS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int BO_BITS  = $clog2(BLK_WORDS);
  localparam int IDX_BITS = $clog2(SETS);
  localparam int TAG_W    = 30 - BO_BITS - IDX_BITS;
  localparam int OFF_W    = (BO_BITS > 0) ? BO_BITS : 1;
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, FILL} state_e;

  state_e                         state_q, state_d;
  logic [OFF_W-1:0]               cnt_q, cnt_d;
  logic [TAG_W-1:0]               ftag_q, ftag_d;
  logic [IDX_BITS-1:0]            fidx_q, fidx_d;
  logic [WAY_W-1:0]               fway_q, fway_d;
  logic [SETS-1:0][WAYS-1:0]      valid_q, valid_d;
  logic [SETS-1:0][WAY_W-1:0]     rr_q, rr_d;
  logic                           iren_q, iren_d;
  logic [31:0]                    iaddr_q, iaddr_d;

  logic [TAG_W-1:0]               tag_mem  [SETS][WAYS];
  logic [31:0]                    data_mem [SETS][WAYS][BLK_WORDS];

  logic [TAG_W-1:0]               req_tag;
  logic [IDX_BITS-1:0]            req_idx;
  logic [OFF_W-1:0]               req_off;
  logic                           hit_any;
  logic [WAY_W-1:0]               hit_way;
  logic [WAY_W-1:0]               victim;
  logic                           found_inv;
  logic                           fill_we;
  logic                           line_set;
  logic                           unused_byte_off;

  assign req_tag         = imemaddr[31 -: TAG_W];
  assign req_idx         = imemaddr[2+BO_BITS +: IDX_BITS];
  assign unused_byte_off = ^imemaddr[1:0];

  if (BO_BITS > 0) begin : g_off
    assign req_off = imemaddr[2 +: BO_BITS];
  end else begin : g_nooff
    assign req_off = '0;
  end

  function automatic logic [31:0] fill_addr(input logic [TAG_W-1:0]    t,
                                            input logic [IDX_BITS-1:0] i,
                                            input logic [OFF_W-1:0]    c);
    logic [31:0] w;
    w = (32'(t) << (2 + BO_BITS + IDX_BITS)) | (32'(i) << (2 + BO_BITS));
    if (BO_BITS > 0) w = w | (32'(c) << 2);
    return w;
  endfunction

  // Tag lookup and victim choice: first invalid way wins, else the set's round-robin way.
  always_comb begin
    hit_any   = 1'b0;
    hit_way   = '0;
    found_inv = 1'b0;
    victim    = (WAYS > 1) ? rr_q[req_idx] : '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && tag_mem[req_idx][w] == req_tag) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!found_inv && !valid_q[req_idx][w]) begin
        found_inv = 1'b1;
        victim    = WAY_W'(w);
      end
    end
  end

  assign ihit = imemREN && (state_q == IDLE) && hit_any && !iflush;

  always_comb begin
    imemload = '0;
    if (ihit) imemload = data_mem[req_idx][hit_way][req_off];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ftag_d   = ftag_q;
    fidx_d   = fidx_q;
    fway_d   = fway_q;
    valid_d  = valid_q;
    rr_d     = rr_q;
    fill_we  = 1'b0;
    line_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (iflush) begin
          valid_d = '0;
        end else if (imemREN && !hit_any) begin
          state_d = FILL;
          cnt_d   = '0;
          ftag_d  = req_tag;
          fidx_d  = req_idx;
          fway_d  = victim;
        end
      end
      FILL: begin
        // A flush abandons the fill; the half-written line was never marked valid.
        if (iflush) begin
          valid_d = '0;
          state_d = IDLE;
        end else if (!iwait) begin
          fill_we = 1'b1;
          cnt_d   = cnt_q + OFF_W'(1);
          if (cnt_q == OFF_W'(BLK_WORDS - 1)) begin
            line_set                = 1'b1;
            valid_d[fidx_q][fway_q] = 1'b1;
            if (WAYS > 1) rr_d[fidx_q] = rr_q[fidx_q] + WAY_W'(1);
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    iren_d  = (state_d == FILL);
    iaddr_d = iren_d ? fill_addr(ftag_d, fidx_d, cnt_d) : '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ftag_q  <= '0;
      fidx_q  <= '0;
      fway_q  <= '0;
      valid_q <= '0;
      rr_q    <= '0;
      iren_q  <= 1'b0;
      iaddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ftag_q  <= ftag_d;
      fidx_q  <= fidx_d;
      fway_q  <= fway_d;
      valid_q <= valid_d;
      rr_q    <= rr_d;
      iren_q  <= iren_d;
      iaddr_q <= iaddr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_we)  data_mem[fidx_q][fway_q][cnt_q] <= iload;
    if (line_set) tag_mem[fidx_q][fway_q]         <= ftag_q;
  end

  assign iREN  = iren_q;
  assign iaddr = iaddr_q;

endmodule

// File: tb/tb_icache_assoc.sv
// Scoreboard bench for icache_assoc (SETS=8, WAYS=2, BLK_WORDS=2) with a wait-state memory model.
`timescale 1ns/1ps
module tb_icache_assoc;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = 32'h0;
  logic        iflush = 1'b0;
  logic        iwait = 1'b1;
  logic [31:0] iload = 32'h0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;

  always #5 CLK = ~CLK;

  icache_assoc #(.SETS(8), .WAYS(2), .BLK_WORDS(2)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .iflush(iflush),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload)
  );

  // mask bits: 0 ihit, 1 imemload, 2 iREN, 3 iaddr, 4 latency, 5 scoreboard drained
  typedef struct {
    int          id;
    logic [5:0]  mask;
    logic        e_hit;
    logic [31:0] e_load;
    logic        e_iren;
    logic [31:0] e_iaddr;
    int          act;
    int          exp;
  } probe_t;

  probe_t      probeq[$];
  logic [31:0] hitq[$];
  logic [31:0] addrq[$];
  probe_t      mp;
  logic [31:0] mexp;
  int          checks = 0;
  int          errors = 0;
  int          wait_cfg = 0;
  int          wcnt = 0;

  // Memory: wait_cfg busy cycles, then one data cycle; data word is 0xC0DE_<addr[15:0]>.
  always @(posedge CLK) begin
    #2;
    if (iREN === 1'b1) begin
      if (wcnt < wait_cfg) begin
        iwait = 1'b1;
        wcnt  = wcnt + 1;
      end else begin
        iwait = 1'b0;
        wcnt  = 0;
      end
      iload = {16'hC0DE, iaddr[15:0]};
    end else begin
      iwait = 1'b1;
      wcnt  = 0;
      iload = 32'h0;
    end
  end

  always @(negedge CLK) begin
    while (probeq.size() != 0) begin
      mp = probeq.pop_front();
      if (mp.mask[0]) begin
        checks++;
        if (ihit !== mp.e_hit) begin
          errors++;
          $display("FAIL p%0d ihit: got %b, want %b", mp.id, ihit, mp.e_hit);
        end
      end
      if (mp.mask[1]) begin
        checks++;
        if (imemload !== mp.e_load) begin
          errors++;
          $display("FAIL p%0d imemload: got %h, want %h", mp.id, imemload, mp.e_load);
        end
      end
      if (mp.mask[2]) begin
        checks++;
        if (iREN !== mp.e_iren) begin
          errors++;
          $display("FAIL p%0d iREN: got %b, want %b", mp.id, iREN, mp.e_iren);
        end
      end
      if (mp.mask[3]) begin
        checks++;
        if (iaddr !== mp.e_iaddr) begin
          errors++;
          $display("FAIL p%0d iaddr: got %h, want %h", mp.id, iaddr, mp.e_iaddr);
        end
      end
      if (mp.mask[4]) begin
        checks++;
        if (mp.act != mp.exp) begin
          errors++;
          $display("FAIL p%0d hit_latency: got %0d cycles, want %0d", mp.id, mp.act, mp.exp);
        end
      end
      if (mp.mask[5]) begin
        checks++;
        if (hitq.size() != 0 || addrq.size() != 0) begin
          errors++;
          $display("FAIL p%0d drain: hits left %0d, fills left %0d, want 0 and 0",
                   mp.id, hitq.size(), addrq.size());
        end
      end
    end
    if (ihit === 1'b1) begin
      checks++;
      if (hitq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_hit: imemaddr %h imemload %h, want no hit", imemaddr, imemload);
      end else begin
        mexp = hitq.pop_front();
        if (imemload !== mexp) begin
          errors++;
          $display("FAIL hit_data @%h: got %h, want %h", imemaddr, imemload, mexp);
        end
      end
    end
    if (iREN === 1'b1 && iwait === 1'b0) begin
      checks++;
      if (addrq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_fill: iaddr %h, want no memory transfer", iaddr);
      end else begin
        mexp = addrq.pop_front();
        if (iaddr !== mexp) begin
          errors++;
          $display("FAIL fill_addr: got %h, want %h", iaddr, mexp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic probe(input int id, input logic [5:0] m, input logic h, input logic [31:0] l,
                       input logic r, input logic [31:0] a, input int act, input int ex);
    probe_t p;
    p.id = id; p.mask = m; p.e_hit = h; p.e_load = l;
    p.e_iren = r; p.e_iaddr = a; p.act = act; p.exp = ex;
    probeq.push_back(p);
  endtask

  // Fetch one word; lat>0 means a miss filling the block at base with that penalty.
  task automatic fetch(input int id, input logic [31:0] a, input logic [31:0] e_word,
                       input logic [31:0] base, input int lat);
    int cyc;
    imemaddr = a;
    imemREN  = 1'b1;
    hitq.push_back(e_word);
    if (lat > 0)
      for (int k = 0; k < 2; k++) addrq.push_back(base + 32'(4 * k));
    cyc = 0;
    #1;
    while (ihit !== 1'b1 && cyc < 200) begin
      probe(id, 6'b000100, 1'b0, 32'h0, (cyc >= 1 && cyc < lat), 32'h0, 0, 0);
      @(posedge CLK);
      #2;
      cyc++;
    end
    probe(id, 6'b010000, 1'b0, 32'h0, 1'b0, 32'h0, cyc, lat);
    @(posedge CLK);
    #1;
    imemREN = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    tick();
    tick();
    probe(1, 6'b001111, 1'b0, 32'h0, 1'b0, 32'h0, 0, 0);
    tick();
    RST = 1'b0;
    tick();

    // 1: cold miss, 2 wait cycles per word, then sibling word hits
    wait_cfg = 2;
    fetch(10, 32'h40, 32'hC0DE0040, 32'h40, 7);
    fetch(11, 32'h44, 32'hC0DE0044, 32'h0, 0);

    // 2: conflicts in set 0 and round-robin eviction
    wait_cfg = 0;
    fetch(20, 32'h80, 32'hC0DE0080, 32'h80, 3);
    fetch(21, 32'hC0, 32'hC0DE00C0, 32'hC0, 3);
    fetch(22, 32'h84, 32'hC0DE0084, 32'h0, 0);
    fetch(23, 32'h40, 32'hC0DE0040, 32'h40, 3);
    fetch(24, 32'hC4, 32'hC0DE00C4, 32'h0, 0);
    fetch(25, 32'h80, 32'hC0DE0080, 32'h80, 3);
    fetch(26, 32'h44, 32'hC0DE0044, 32'h0, 0);

    // 3: flush in IDLE while 0x40 is requested
    imemaddr = 32'h40;
    imemREN  = 1'b1;
    iflush   = 1'b1;
    probe(30, 6'b000111, 1'b0, 32'h0, 1'b0, 32'h0, 0, 0);
    tick();
    iflush  = 1'b0;
    imemREN = 1'b0;
    probe(31, 6'b000100, 1'b0, 32'h0, 1'b0, 32'h0, 0, 0);
    tick();
    fetch(32, 32'h40, 32'hC0DE0040, 32'h40, 3);
    fetch(33, 32'h80, 32'hC0DE0080, 32'h80, 3);

    // 4: flush during the word-0 request of a 0x100 fill
    wait_cfg = 3;
    imemaddr = 32'h100;
    imemREN  = 1'b1;
    probe(40, 6'b000101, 1'b0, 32'h0, 1'b0, 32'h0, 0, 0);
    tick();
    probe(41, 6'b001100, 1'b0, 32'h0, 1'b1, 32'h100, 0, 0);
    iflush = 1'b1;
    tick();
    iflush  = 1'b0;
    imemREN = 1'b0;
    probe(42, 6'b000101, 1'b0, 32'h0, 1'b0, 32'h0, 0, 0);
    tick();
    wait_cfg = 0;
    fetch(43, 32'h100, 32'hC0DE0100, 32'h100, 3);
    fetch(44, 32'h40, 32'hC0DE0040, 32'h40, 3);

    // 5: no request on a missing address
    imemaddr = 32'h200;
    imemREN  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      probe(50 + i, 6'b000111, 1'b0, 32'h0, 1'b0, 32'h0, 0, 0);
      tick();
    end

    // 6: reset during the word-1 request of a 0x40 fill
    wait_cfg = 1;
    iflush   = 1'b1;
    tick();
    iflush   = 1'b0;
    imemaddr = 32'h40;
    imemREN  = 1'b1;
    addrq.push_back(32'h40);
    probe(60, 6'b000101, 1'b0, 32'h0, 1'b0, 32'h0, 0, 0);
    tick();
    probe(61, 6'b001100, 1'b0, 32'h0, 1'b1, 32'h40, 0, 0);
    tick();
    probe(62, 6'b001100, 1'b0, 32'h0, 1'b1, 32'h40, 0, 0);
    tick();
    probe(63, 6'b001100, 1'b0, 32'h0, 1'b1, 32'h44, 0, 0);
    RST     = 1'b1;
    imemREN = 1'b0;
    tick();
    probe(64, 6'b001101, 1'b0, 32'h0, 1'b0, 32'h0, 0, 0);
    RST = 1'b0;
    tick();
    fetch(65, 32'h40, 32'hC0DE0040, 32'h40, 5);
    fetch(66, 32'h44, 32'hC0DE0044, 32'h0, 0);

    tick();
    probe(99, 6'b100000, 1'b0, 32'h0, 1'b0, 32'h0, 0, 0);
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
